// File: rtl/codificator_instructiuni_if.sv
// Field-input and instruction-memory write signals of the instruction encoder.
// slave is the encoder's view; master is the program-load source plus memory side.
interface codificator_instructiuni_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              format;
    logic [3:0]        opcode;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [3:0]        rd;
    logic [7:0]        immediate;
    logic              load_addr;
    logic [ADDR_W-1:0] start_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_full;
    logic              busy;
    logic [ADDR_W:0]   word_count;

    modport slave (
        input  in_valid, format, opcode, rs, rt, rd, immediate,
        input  load_addr, start_addr, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_full, busy, word_count
    );

    modport master (
        output in_valid, format, opcode, rs, rt, rd, immediate,
        output load_addr, start_addr, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_full, busy, word_count
    );
endinterface

// File: rtl/codificator_instructiuni.sv
// Packs R/I-type fields into 16-bit instruction words and streams them through a
// small FIFO into sequential instruction-memory addresses.
module codificator_instructiuni #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    codificator_instructiuni_if.slave  bus,
    output logic [1:0]                 fsm_state
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]    DEPTH     = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_MEMFULL = 2'd2;

    // Handshakes: a field set is accepted on in_valid && in_ready, and a word is
    // written on mem_we && mem_ready; mem_we/mem_addr/mem_wdata hold while mem_ready is low.
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   words;
    logic [15:0]       encoded;
    logic              fifo_full;
    logic              fifo_empty;
    logic              mem_full;
    logic              ready;
    logic              we;
    logic              push;
    logic              pop;

    assign encoded    = bus.format ? {bus.opcode, bus.rs, bus.immediate}
                                   : {bus.opcode, bus.rs, bus.rt, bus.rd};
    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);
    assign mem_full   = (state == S_MEMFULL);

    // in_ready only looks at registered flags, so a push never lands on a full FIFO.
    assign ready = !rst && !fifo_full && !mem_full && !bus.load_addr;
    assign we    = !fifo_empty && !mem_full;
    assign push  = bus.in_valid && ready;
    assign pop   = we && bus.mem_ready;

    assign bus.in_ready   = ready;
    assign bus.mem_we     = we;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = we ? fifo_mem[rd_ptr] : 16'h0000;
    assign bus.mem_full   = mem_full;
    assign bus.busy       = !fifo_empty;
    assign bus.word_count = words;
    assign fsm_state      = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (push) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (pop && addr == LAST_ADDR)                   state_next = S_MEMFULL;
                else if (pop && !push && count == (PTR_W+1)'(1)) state_next = S_IDLE;
            end
            S_MEMFULL: state_next = S_MEMFULL;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= encoded;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= '0;
            words  <= '0;
        end else if (bus.load_addr) begin
            // A write the memory takes in this cycle is deliberately not counted.
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= bus.start_addr;
            words  <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                addr   <= addr + ADDR_W'(1);
                words  <= words + (ADDR_W+1)'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_codificator_instructiuni.sv
// Bench for the instruction encoder: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the write stream.
module tb_codificator_instructiuni;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;

    codificator_instructiuni_if #(.ADDR_W(ADDR_W)) bus ();

    codificator_instructiuni #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    // Model: pending words in push order, next write address, words written, halted flag.
    logic [15:0]       exp_q[$];
    int unsigned       m_addr  = 0;
    int unsigned       m_count = 0;
    bit                m_full  = 1'b0;
    bit                m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input bit fmt, input int unsigned op, input int unsigned s,
                                        input int unsigned t, input int unsigned d, input int unsigned imm);
        int unsigned v;
        if (fmt) v = op * 4096 + s * 256 + imm;
        else     v = op * 4096 + s * 256 + t * 16 + d;
        return v[15:0];
    endfunction

    task automatic set_word(input bit fmt, input int unsigned op, input int unsigned s,
                            input int unsigned t, input int unsigned d, input int unsigned imm);
        bus.in_valid  = 1'b1;
        bus.format    = fmt;
        bus.opcode    = op[3:0];
        bus.rs        = s[3:0];
        bus.rt        = t[3:0];
        bus.rd        = d[3:0];
        bus.immediate = imm[7:0];
    endtask

    task automatic set_random_word();
        set_word($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
    endtask

    // One clock: compare against the model at negedge, then advance the model at posedge.
    task automatic step();
        bit          exp_ready;
        bit          exp_we;
        bit          do_push;
        bit          do_pop;
        logic [15:0] w;
        @(negedge clk);
        exp_ready = !rst && (exp_q.size() < DEPTH) && !m_full && !bus.load_addr;
        exp_we    = (exp_q.size() > 0) && !m_full;
        if (m_valid) begin
            check("in_ready",   bus.in_ready,   exp_ready);
            check("mem_we",     bus.mem_we,     exp_we);
            check("mem_addr",   bus.mem_addr,   m_addr);
            check("mem_full",   bus.mem_full,   m_full);
            check("busy",       bus.busy,       exp_q.size() > 0);
            check("word_count", bus.word_count, m_count);
            if (exp_we) check("mem_wdata", bus.mem_wdata, exp_q[0]);
        end
        if (bus.in_valid && bus.in_ready) n_acc++;
        do_push = bus.in_valid && exp_ready;
        do_pop  = exp_we && bus.mem_ready;
        w = enc(bus.format, bus.opcode, bus.rs, bus.rt, bus.rd, bus.immediate);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_addr = 0; m_count = 0; m_full = 1'b0; m_valid = 1'b1;
        end else if (bus.load_addr) begin
            exp_q.delete();
            m_addr = bus.start_addr; m_count = 0; m_full = 1'b0;
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                m_count++;
                if (m_addr == (1 << ADDR_W) - 1) m_full = 1'b1;
                m_addr = (m_addr + 1) % (1 << ADDR_W);
            end
            if (do_push) exp_q.push_back(w);
        end
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.format = 1'b0; bus.opcode = 4'h0; bus.rs = 4'h0;
        bus.rt = 4'h0; bus.rd = 4'h0; bus.immediate = 8'h00; bus.load_addr = 1'b0;
        bus.start_addr = '0; bus.mem_ready = 1'b0;

        // Reset: second cycle is compared with rst still high.
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_wdata", bus.mem_wdata, 16'h0000);
        check("post_rst_ready", bus.in_ready, 1'b1);

        // R-type encoding
        bus.mem_ready = 1'b1;
        set_word(1'b0, 3, 1, 2, 4, 8'h00);
        step();
        bus.in_valid = 1'b0;
        check("r_we", bus.mem_we, 1'b1);
        check("r_addr", bus.mem_addr, 8'h00);
        check("r_data", bus.mem_wdata, 16'h3124);
        step();
        check("r_count", bus.word_count, 1);

        // I-type encoding, rt/rd garbage
        set_word(1'b1, 9, 5, 15, 15, 8'hA7);
        step();
        bus.in_valid = 1'b0;
        check("i_data", bus.mem_wdata, 16'h95A7);
        check("i_addr", bus.mem_addr, 8'h01);
        step();

        // Backpressure: five offers, four accepted, then drain one per cycle
        bus.mem_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            set_random_word();
            step();
        end
        check("bp_accepts", n_acc, 4);
        check("bp_ready_low", bus.in_ready, 1'b0);
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("bp_drained", bus.busy, 1'b0);
        check("bp_count", bus.word_count, 6);

        // Memory full at the top of the address space
        bus.load_addr = 1'b1; bus.start_addr = 8'hFE;
        step();
        bus.load_addr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_random_word();
            step();
        end
        bus.in_valid = 1'b0;
        check("mf_full", bus.mem_full, 1'b1);
        check("mf_we", bus.mem_we, 1'b0);
        check("mf_ready", bus.in_ready, 1'b0);
        check("mf_busy", bus.busy, 1'b1);
        check("mf_count", bus.word_count, 2);
        step();
        bus.load_addr = 1'b1; bus.start_addr = 8'h10;
        step();
        bus.load_addr = 1'b0;
        check("mf_clear_full", bus.mem_full, 1'b0);
        check("mf_clear_busy", bus.busy, 1'b0);
        check("mf_clear_count", bus.word_count, 0);
        check("mf_clear_addr", bus.mem_addr, 8'h10);

        // load_addr while words are queued and a word is offered
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_random_word();
            step();
        end
        set_random_word();
        bus.load_addr = 1'b1; bus.start_addr = 8'h40;
        #1;
        check("ld_no_accept", bus.in_ready, 1'b0);
        step();
        bus.load_addr = 1'b0;
        bus.in_valid  = 1'b0;
        check("ld_flushed", bus.busy, 1'b0);
        set_word(1'b0, 7, 6, 5, 4, 0);
        bus.mem_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("ld_addr", bus.mem_addr, 8'h40);
        check("ld_data", bus.mem_wdata, 16'h7654);
        step();

        // Reset in the middle of traffic
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_random_word();
            step();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mr_we", bus.mem_we, 1'b0);
        check("mr_busy", bus.busy, 1'b0);
        check("mr_count", bus.word_count, 0);
        check("mr_addr", bus.mem_addr, 8'h00);
        set_random_word();
        step();
        bus.in_valid = 1'b0;
        check("mr_next_addr", bus.mem_addr, 8'h00);
        check("mr_next_we", bus.mem_we, 1'b1);
        bus.mem_ready = 1'b1;
        step();

        // Random traffic with occasional reloads near the top and rare resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.load_addr = !rst && ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) bus.start_addr = 8'($urandom_range(240, 255));
            else                           bus.start_addr = 8'($urandom_range(0, 255));
            set_random_word();
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.mem_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 1'b0;
        bus.load_addr = 1'b0;
        bus.in_valid  = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
